cl_irq_sched: RTL and testbench

Interrupt scheduler for the application PF IRQ interface. It collects per-vector interrupt events from CL logic and software, and arbitrates round-robin among pending, unmasked vectors. It issues one single-cycle request at a time to the shell, then waits for the matching ack or a programmable timeout. It is configured and observed through a cfg-bus slave port and sits between CL event sources and cl_sh_apppf_irq_req/sh_cl_apppf_irq_ack.

---
 rtl/cl_irq_sched.sv | 197 +++++++++++++++++++
 tb/tb_cl_irq_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cl_irq_sched.sv
// Round-robin interrupt scheduler: collects per-vector events, issues one-hot
// single-cycle requests to the shell and waits for the matching ack or a timeout.
module cl_irq_sched #(
    parameter int          NUM_VEC         = 16,
    parameter int          TIMEOUT_W       = 16,
    parameter int unsigned DEFAULT_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cfg_addr,
    input  logic [31:0]          cfg_wdata,
    input  logic                 cfg_wr,
    input  logic                 cfg_rd,
    output logic                 cfg_ack,
    output logic [31:0]          cfg_rdata,
    input  logic [NUM_VEC-1:0]   evt_in,
    output logic [NUM_VEC-1:0]   cl_sh_irq_req,
    input  logic [NUM_VEC-1:0]   sh_cl_irq_ack,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t               state, state_nxt;
    logic                 ctrl_en, ctrl_en_nxt;
    logic [NUM_VEC-1:0]   mask, mask_nxt;
    logic [NUM_VEC-1:0]   pend, pend_nxt;
    logic [NUM_VEC-1:0]   err, err_nxt;
    logic [TIMEOUT_W-1:0] timeout, timeout_nxt;
    logic [TIMEOUT_W-1:0] timer, timer_nxt;
    logic [31:0]          issue_cnt, issue_cnt_nxt;
    logic [3:0]           ptr, ptr_nxt;
    logic [3:0]           cur_vec, cur_vec_nxt;
    logic [NUM_VEC-1:0]   req_nxt;
    logic                 busy_nxt;
    logic [31:0]          rdata_nxt;

    logic [NUM_VEC-1:0]   elig;
    logic [NUM_VEC-1:0]   sel_onehot;
    logic [NUM_VEC-1:0]   issue_clr;
    logic [NUM_VEC-1:0]   err_set;
    logic [NUM_VEC-1:0]   pend_wr_set;
    logic [NUM_VEC-1:0]   err_wr_clr;
    logic [3:0]           sel;
    logic                 found;

    assign elig       = pend & ~mask;
    assign sel_onehot = NUM_VEC'(1'b1) << sel;

    // Round-robin search: first eligible vector above the pointer, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = 4'd0;
        idx   = 0;
        for (int i = 1; i <= NUM_VEC; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_VEC) begin
                idx = idx - NUM_VEC;
            end else begin
                idx = idx;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = 4'(idx);
            end else begin
                found = found;
            end
        end
    end

    // Register-file writes and read mux.
    always_comb begin
        ctrl_en_nxt = ctrl_en;
        mask_nxt    = mask;
        timeout_nxt = timeout;
        pend_wr_set = '0;
        err_wr_clr  = '0;
        if (cfg_wr) begin
            case (cfg_addr)
                32'h0000_0000: ctrl_en_nxt = cfg_wdata[0];
                32'h0000_0004: mask_nxt    = cfg_wdata[NUM_VEC-1:0];
                32'h0000_0008: pend_wr_set = cfg_wdata[NUM_VEC-1:0];
                32'h0000_000C: timeout_nxt = cfg_wdata[TIMEOUT_W-1:0];
                32'h0000_0014: err_wr_clr  = cfg_wdata[NUM_VEC-1:0];
                default:       ctrl_en_nxt = ctrl_en;
            endcase
        end else begin
            ctrl_en_nxt = ctrl_en;
        end

        rdata_nxt = 32'h0000_0000;
        if (cfg_rd) begin
            case (cfg_addr)
                32'h0000_0000: rdata_nxt = 32'(ctrl_en);
                32'h0000_0004: rdata_nxt = 32'(mask);
                32'h0000_0008: rdata_nxt = 32'(pend);
                32'h0000_000C: rdata_nxt = 32'(timeout);
                32'h0000_0010: rdata_nxt = {24'h00_0000, cur_vec, 2'b00, (state == WAIT), busy};
                32'h0000_0014: rdata_nxt = 32'(err);
                32'h0000_0018: rdata_nxt = issue_cnt;
                default:       rdata_nxt = 32'h0BAD_ADD0;
            endcase
        end else begin
            rdata_nxt = 32'h0000_0000;
        end
    end

    // Issue FSM next-state and outputs.
    always_comb begin
        state_nxt     = state;
        req_nxt       = '0;
        issue_clr     = '0;
        err_set       = '0;
        issue_cnt_nxt = issue_cnt;
        timer_nxt     = timer;
        ptr_nxt       = ptr;
        cur_vec_nxt   = cur_vec;
        case (state)
            IDLE: begin
                if (ctrl_en && found) begin
                    req_nxt     = sel_onehot;
                    issue_clr   = sel_onehot;
                    ptr_nxt     = sel;
                    cur_vec_nxt = sel;
                    timer_nxt   = timeout;
                    state_nxt   = REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // An ack wins over a timer expiring in the same cycle.
                if (sh_cl_irq_ack[cur_vec]) begin
                    issue_cnt_nxt = issue_cnt + 32'd1;
                    state_nxt     = IDLE;
                end else if (timer != '0) begin
                    timer_nxt = timer - TIMEOUT_W'(1);
                    if (timer == TIMEOUT_W'(1)) begin
                        err_set[cur_vec] = 1'b1;
                        state_nxt        = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    state_nxt = WAIT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
        // Set sources win over the issue-clear so a coincident event re-pends.
        pend_nxt = (pend & ~issue_clr) | evt_in | pend_wr_set;
        err_nxt  = (err & ~err_wr_clr) | err_set;
    end

    // State and register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ctrl_en       <= 1'b0;
            mask          <= '0;
            pend          <= '0;
            err           <= '0;
            timeout       <= TIMEOUT_W'(DEFAULT_TIMEOUT);
            timer         <= '0;
            issue_cnt     <= 32'd0;
            ptr           <= 4'(NUM_VEC - 1);
            cur_vec       <= 4'd0;
            cl_sh_irq_req <= '0;
            busy          <= 1'b0;
            cfg_ack       <= 1'b0;
            cfg_rdata     <= 32'h0000_0000;
        end else begin
            state         <= state_nxt;
            ctrl_en       <= ctrl_en_nxt;
            mask          <= mask_nxt;
            pend          <= pend_nxt;
            err           <= err_nxt;
            timeout       <= timeout_nxt;
            timer         <= timer_nxt;
            issue_cnt     <= issue_cnt_nxt;
            ptr           <= ptr_nxt;
            cur_vec       <= cur_vec_nxt;
            cl_sh_irq_req <= req_nxt;
            busy          <= busy_nxt;
            cfg_ack       <= cfg_wr | cfg_rd;
            cfg_rdata     <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_cl_irq_sched.sv
// Scoreboard bench for cl_irq_sched: expected request vectors are queued at
// stimulus time and matched against each request the DUT raises.
module tb_cl_irq_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wr;
    logic        cfg_rd;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;
    logic [15:0] evt_in;
    logic [15:0] cl_sh_irq_req;
    logic [15:0] sh_cl_irq_ack;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    bit auto_ack = 1'b1;
    int ack_dly  = 1;
    int ack_cnt  = 0;
    int ack_vec  = 0;
    bit prev_req = 1'b0;

    cl_irq_sched dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_wr        (cfg_wr),
        .cfg_rd        (cfg_rd),
        .cfg_ack       (cfg_ack),
        .cfg_rdata     (cfg_rdata),
        .evt_in        (evt_in),
        .cl_sh_irq_req (cl_sh_irq_req),
        .sh_cl_irq_ack (sh_cl_irq_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Request monitor and shell ack responder.
    initial begin
        sh_cl_irq_ack = 16'h0000;
        forever begin
            @(negedge clk);
            sh_cl_irq_ack = 16'h0000;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) sh_cl_irq_ack = 16'd1 << ack_vec;
            end
            if (cl_sh_irq_req != 16'h0000) begin
                check_val("req_1cyc", 32'(prev_req), 32'd0);
                if (exp_q.size() == 0) begin
                    check_val("req_unexp", 32'(cl_sh_irq_req), 32'd0);
                end else begin
                    int v;
                    logic [15:0] oh;
                    v  = exp_q.pop_front();
                    oh = 16'd1 << v;
                    check_val("req_vec", 32'(cl_sh_irq_req), 32'(oh));
                    if (auto_ack) begin
                        ack_cnt = ack_dly;
                        ack_vec = v;
                    end
                end
            end
            prev_req = (cl_sh_irq_req != 16'h0000);
        end
    end

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        cfg_addr  = addr;
        cfg_wdata = data;
        cfg_wr    = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        check_val("wr_ack", 32'(cfg_ack), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        cfg_addr = addr;
        cfg_rd   = 1'b1;
        @(negedge clk);
        cfg_rd = 1'b0;
        check_val("rd_ack", 32'(cfg_ack), 32'd1);
        check_val(tag, cfg_rdata, exp);
    endtask

    task automatic pulse_and_see(input int v);
        logic [15:0] oh;
        oh = 16'd1 << v;
        exp_q.push_back(v);
        evt_in = oh;
        @(negedge clk);
        evt_in = 16'h0000;
        check_val("lat_early", 32'(cl_sh_irq_req), 32'd0);
        @(negedge clk);
        check_val("lat_req", 32'(cl_sh_irq_req), 32'(oh));
    endtask

    task automatic wait_idle(input int budget, output int wcyc);
        bit done;
        done = 1'b0;
        wcyc = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (busy) wcyc++;
            else if (exp_q.size() == 0 && cl_sh_irq_req == 16'h0000) done = 1'b1;
        end
        check_val("idle_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        rst = 1'b1; cfg_addr = 32'h0; cfg_wdata = 32'h0; cfg_wr = 1'b0; cfg_rd = 1'b0;
        evt_in = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_req", 32'(cl_sh_irq_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ack", 32'(cfg_ack), 32'd0);
        check_val("rst_rdata", cfg_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd_chk("rst_timeout", 32'h0C, 32'd1000);
        rd_chk("rst_status", 32'h10, 32'd0);
        rd_chk("rst_pend", 32'h08, 32'd0);

        // 1: single event, ack after 5 cycles
        cfg_write(32'h00, 32'd1);
        ack_dly = 5;
        pulse_and_see(3);
        wait_idle(50, wc);
        check_val("t1_wait_cyc", 32'(wc), 32'd5);
        rd_chk("t1_cnt", 32'h18, 32'd1);
        rd_chk("t1_pend", 32'h08, 32'd0);
        check_val("t1_busy", 32'(busy), 32'd0);

        // 4: masked vector stays pending, issues on unmask (pointer -> 0)
        ack_dly = 1;
        cfg_write(32'h04, 32'h1);
        evt_in = 16'h0001;
        @(negedge clk);
        evt_in = 16'h0000;
        repeat (5) @(negedge clk);
        check_val("t4_busy", 32'(busy), 32'd0);
        rd_chk("t4_pend", 32'h08, 32'h1);
        exp_q.push_back(0);
        cfg_write(32'h04, 32'h0);
        wait_idle(50, wc);
        rd_chk("t4_pend_clr", 32'h08, 32'h0);

        // 2: round robin from pointer 0 over 2, 15, 0
        exp_q.push_back(2); exp_q.push_back(15); exp_q.push_back(0);
        cfg_write(32'h08, 32'h8005);
        wait_idle(100, wc);
        rd_chk("t2_cnt", 32'h18, 32'd5);
        rd_chk("t2_pend", 32'h08, 32'h0);

        // 3: timeout sets sticky error, W1C clears it
        auto_ack = 1'b0;
        cfg_write(32'h0C, 32'd4);
        pulse_and_see(1);
        wait_idle(50, wc);
        check_val("t3_wait_cyc", 32'(wc), 32'd4);
        rd_chk("t3_err", 32'h14, 32'h2);
        rd_chk("t3_cnt", 32'h18, 32'd5);
        rd_chk("t3_status", 32'h10, 32'h10);
        rd_chk("t3_pend", 32'h08, 32'h0);
        cfg_write(32'h14, 32'h2);
        rd_chk("t3_err_clr", 32'h14, 32'h0);
        cfg_write(32'h0C, 32'd1000);
        auto_ack = 1'b1;

        // 5: event coincident with issue re-pends the vector
        ack_dly = 4;
        exp_q.push_back(6); exp_q.push_back(6);
        evt_in = 16'h0040;
        @(negedge clk);
        @(negedge clk);
        evt_in = 16'h0000;
        rd_chk("t5_repend", 32'h08, 32'h40);
        wait_idle(100, wc);
        rd_chk("t5_cnt", 32'h18, 32'd7);
        rd_chk("t5_pend", 32'h08, 32'h0);

        // 6: unmapped access, then reset during WAIT
        rd_chk("t6_unmapped", 32'h20, 32'h0BAD_ADD0);
        cfg_write(32'h24, 32'hFFFF_FFFF);
        rd_chk("t6_ctrl", 32'h00, 32'h1);
        rd_chk("t6_mask", 32'h04, 32'h0);
        auto_ack = 1'b0;
        cfg_write(32'h0C, 32'd0);
        pulse_and_see(5);
        repeat (3) @(negedge clk);
        check_val("t6_busy", 32'(busy), 32'd1);
        rd_chk("t6_status", 32'h10, 32'h53);
        rst = 1'b1;
        #1;
        check_val("t6_rst_req", 32'(cl_sh_irq_req), 32'd0);
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_ack", 32'(cfg_ack), 32'd0);
        check_val("t6_rst_rdata", cfg_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_chk("t6_timeout", 32'h0C, 32'd1000);
        rd_chk("t6_err", 32'h14, 32'h0);
        rd_chk("t6_cnt", 32'h18, 32'd0);
        rd_chk("t6_ctrl_rst", 32'h00, 32'h0);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
